// File: rtl/ppm_mod_if.sv
// Symbol input handshake and PPM pulse outputs of the ppm_mod 4-PPM transmitter.
interface ppm_mod_if;
    logic [1:0] din;
    logic       dinValid;
    logic       dinReady;
    logic       dout;
    logic       busy;
    logic       symDone;

    modport master (
        output din, dinValid,
        input  dinReady, dout, busy, symDone
    );

    modport slave (
        input  din, dinValid,
        output dinReady, dout, busy, symDone
    );
endinterface

// File: rtl/ppm_mod.sv
// 4-PPM transmit modulator: each 2-bit symbol becomes four NDATA-cycle slots, one driven high.
// Build option PPM_MOD_GRAY_EN selects inverse-Gray symbol-to-slot mapping instead of binary.
module ppm_mod #(
    parameter int NDATA = 128
) (
    input  logic      clk,
    input  logic      rst,
    ppm_mod_if.slave  bus
);

    localparam int NDATA_LOG = (NDATA > 1) ? $clog2(NDATA) : 1;
    localparam logic [NDATA_LOG-1:0] LAST_SAMPLE = NDATA_LOG'(NDATA - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [1:0]            r_buf_sym;
    logic                  r_buf_full;
    logic [1:0]            r_cur_slot;
    logic [NDATA_LOG-1:0]  r_sample_cnt;
    logic [1:0]            r_slot_cnt;
    logic                  w_load;
    logic                  w_accept;
    logic                  w_sym_end;

    function automatic logic [1:0] map_slot(input logic [1:0] sym);
`ifdef PPM_MOD_GRAY_EN
        // Inverse Gray: neighbouring slots carry codes one bit apart.
        return {sym[1], sym[1] ^ sym[0]};
`else
        return sym;
`endif
    endfunction

    assign w_accept  = bus.dinValid && !r_buf_full;
    assign w_sym_end = (r_state == ST_SEND) && (r_slot_cnt == 2'd3)
                       && (r_sample_cnt == LAST_SAMPLE);

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_buf_full) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                // A buffered symbol chains straight in, so there is no gap cycle.
                if (w_sym_end) begin
                    if (r_buf_full) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_sample_cnt <= '0;
            r_slot_cnt   <= '0;
            r_buf_full   <= 1'b0;
            r_cur_slot   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_cur_slot   <= map_slot(r_buf_sym);
                r_buf_full   <= 1'b0;
                r_sample_cnt <= '0;
                r_slot_cnt   <= '0;
            end else begin
                if (r_state == ST_SEND) begin
                    if (r_sample_cnt == LAST_SAMPLE) begin
                        r_sample_cnt <= '0;
                        r_slot_cnt   <= r_slot_cnt + 2'd1;
                    end else begin
                        r_sample_cnt <= r_sample_cnt + NDATA_LOG'(1);
                    end
                end
                if (w_accept) begin
                    r_buf_full <= 1'b1;
                end
            end
        end
    end

    // Buffered symbol payload needs no reset; r_buf_full qualifies it.
    always_ff @(posedge clk) begin
        if (!rst && w_accept) begin
            r_buf_sym <= bus.din;
        end
    end

    assign bus.dout     = (r_state == ST_SEND) && (r_slot_cnt == r_cur_slot);
    assign bus.busy     = (r_state == ST_SEND);
    assign bus.symDone  = w_sym_end;
    assign bus.dinReady = !r_buf_full;

endmodule
